// File: rtl/mem_bit_master.sv
// Requester-side controller for the bit-masked single-port memory.
// Turns single/burst commands into memory cycles and returns read beats over a backpressured channel.
module mem_bit_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_data,
    input  logic [DATA_W-1:0] req_mask,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,
    output logic              busy,
    output logic              mem_c_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic [DATA_W-1:0] mem_bit_mask,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_left;
    logic [CNT_W-1:0]   r_lat;
    logic               r_mem_c_en;
    logic               r_mem_wr;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wr_data;
    logic [DATA_W-1:0]  r_mem_bit_mask;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_data;

    logic               w_idle;
    logic [ADDR_W-1:0]  w_next_addr;

    assign w_idle      = (r_state == S_IDLE);
    assign w_next_addr = r_addr + ADDR_ONE;

    // Memory-side outputs are registered and loaded one cycle ahead of the beat they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_left         <= '0;
            r_lat          <= '0;
            r_mem_c_en     <= 1'b0;
            r_mem_wr       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wr_data  <= '0;
            r_mem_bit_mask <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && w_idle) begin
                        r_addr     <= req_addr;
                        r_left     <= req_len;
                        r_mem_c_en <= 1'b1;
                        r_mem_addr <= req_addr;
                        if (req_wr) begin
                            r_state        <= S_WRITE;
                            r_mem_wr       <= 1'b1;
                            r_mem_wr_data  <= req_data;
                            r_mem_bit_mask <= req_mask;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_left == '0) begin
                        r_state        <= S_IDLE;
                        r_mem_c_en     <= 1'b0;
                        r_mem_wr       <= 1'b0;
                        r_mem_addr     <= '0;
                        r_mem_wr_data  <= '0;
                        r_mem_bit_mask <= '0;
                    end else begin
                        r_left     <= r_left - LEN_ONE;
                        r_addr     <= w_next_addr;
                        r_mem_addr <= w_next_addr;
                    end
                end
                S_READ: begin
                    r_state    <= S_WAIT;
                    r_mem_c_en <= 1'b0;
                    r_mem_addr <= '0;
                    r_lat      <= LAT_LAST;
                end
                S_WAIT: begin
                    if (r_lat == '0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= mem_rd_data;
                    end else begin
                        r_lat <= r_lat - CNT_ONE;
                    end
                end
                S_RESP: begin
                    // The next read is only issued once the current beat has been taken downstream.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_left == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state    <= S_READ;
                            r_left     <= r_left - LEN_ONE;
                            r_addr     <= w_next_addr;
                            r_mem_addr <= w_next_addr;
                            r_mem_c_en <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = w_idle;
    assign busy         = !w_idle;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign mem_c_en     = r_mem_c_en;
    assign mem_wr       = r_mem_wr;
    assign mem_addr     = r_mem_addr;
    assign mem_wr_data  = r_mem_wr_data;
    assign mem_bit_mask = r_mem_bit_mask;

endmodule
